round_controller: RTL
=====================

Name: round_controller

Overview:
- Game-round sequencer for the reaction game. It sits directly upstream of the millisecond timer and drives that timer's reset, enable, end_value and difficulty inputs.
- It consumes the timer's end_reached and timer_value outputs, plus debounced player hit pulses.
- It tracks score, lives, round count, difficulty level and best reaction time, and signals the display/target logic when to present a new target.

Parameters:
- MAX_MS, 5000, timer range; sets the width TW = $clog2(MAX_MS) of all ms values.
- ROUND_MS, 2000, per-round time limit driven onto timer_end_value.
- NUM_ROUNDS, 10, rounds per game.
- LIVES, 3, misses allowed before game over.
- LEVEL_ROUNDS, 3, correct hits required per difficulty step.
- GAP_CLKS, 25000000, idle clocks between rounds.
- SCORE_W, 8, score width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a new game from IDLE or OVER
- hit  in  1  one-cycle pulse; player pressed a button
- hit_correct  in  1  qualifies hit: pressed button matches the target
- timer_end_reached  in  1  from timer
- timer_value  in  TW  from timer, current ms
- timer_reset  out  1  to timer reset
- timer_enable  out  1  to timer enable
- timer_end_value  out  TW  constant ROUND_MS
- difficulty  out  4  0 easy, 1 medium, 2 hard
- new_target  out  1  one-cycle pulse; display picks a new target
- score  out  SCORE_W  accumulated points
- lives  out  2  remaining lives
- round_idx  out  4  rounds completed
- best_ms  out  TW  fastest correct reaction; all-ones = none yet
- game_over  out  1  high while in OVER

Behaviour:
- Reset values:
  - state = IDLE; score = 0; lives = LIVES; round_idx = 0; difficulty = 0; best_ms = all-ones.
  - new_target = 0; timer_enable = 0; timer_reset = 1; game_over = 0.
- All outputs are registered. timer_end_value is tied to ROUND_MS.
- States: IDLE, ARM, RUN, SCORE, GAP, OVER.
- IDLE:
  - timer_reset = 1.
  - On start: clear score, round_idx, difficulty and best_ms; set lives = LIVES; go to ARM.
- ARM (exactly 1 cycle):
  - timer_reset = 1; new_target pulses on the following cycle; go to RUN.
- RUN:
  - timer_reset = 0, timer_enable = 1.
  - hit && hit_correct (correct hit):
    - score += difficulty + 1, saturating at all-ones.
    - best_ms = min(best_ms, timer_value).
    - Increment the internal correct-hit counter. When it reaches LEVEL_ROUNDS, clear it and step difficulty up, saturating at 2.
    - Go to SCORE.
  - hit && !hit_correct, or timer_end_reached (miss):
    - lives -= 1; go to SCORE.
  - Simultaneous hit and timer_end_reached in the same cycle: the hit takes priority and is evaluated as above.
  - Hits outside RUN are ignored.
- SCORE (1 cycle):
  - timer_reset = 1, timer_enable = 0; round_idx += 1.
  - If lives == 0 or round_idx + 1 == NUM_ROUNDS, go to OVER; else go to GAP.
- GAP:
  - timer_reset = 1. The internal counter counts 0 .. GAP_CLKS-1, then goes to ARM.
  - start is ignored.
- OVER:
  - game_over = 1, timer_reset = 1. score and best_ms hold.
  - On start, behave as in IDLE.
- Reset mid-game: returns to IDLE with reset values on the next edge, regardless of state.
- Round latency: a hit in RUN cycle N produces timer_reset = 1 at N+1. If not over, ARM is entered at N+2+GAP_CLKS.
- The lives decrement never underflows; OVER is reached exactly at lives == 0.

Decomposition:
- game_pkg holds:
  - the state enum;
  - difficulty constants DIFF_EASY = 0, DIFF_MED = 1, DIFF_HARD = 2;
  - a helper function for saturating score add.
- One sub-module, gap_delay: a load/count/done down-counter of GAP_CLKS. It is reusable by the display stage.

Test Plan (all cases GAP_CLKS = 4, ROUND_MS = 20, timer model at 1 ms = 5 clk):
- reset, start, then correct hit at timer_value = 7 -> score = 1, best_ms = 7, round_idx = 1; new_target pulses again 6 cycles after the hit.
- three correct hits, then a fourth at difficulty 1 -> difficulty = 1 after the third hit; the fourth adds 2 points, so score = 5.
- no hit until timer_end_reached for 3 rounds -> lives 3→0, game_over = 1, score = 0, round_idx = 3.
- hit with hit_correct = 1 in the same cycle as timer_end_reached -> scored as correct, lives unchanged.
- 10 correct hits -> OVER after round 10 with difficulty saturated at 2; score = 1+1+1+2+2+2+3+3+3+3 = 21.
- reset asserted during GAP -> next cycle state IDLE, score = 0, timer_reset = 1, new_target never pulses.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and helpers for the reaction-game round sequencer
// Contents: round state enum, difficulty level constants, saturating add helper.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_SCORE,
    ST_GAP,
    ST_OVER
  } round_state_t;

  localparam logic [3:0] DIFF_EASY = 4'd0;
  localparam logic [3:0] DIFF_MED  = 4'd1;
  localparam logic [3:0] DIFF_HARD = 4'd2;

  // Adds a + b and clamps the result at max_val.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_val}) return max_val;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/round_controller_if.sv
// rtl/round_controller_if.sv - control/status bus between round sequencer and ms timer
// Signals: timer_reset, timer_enable, timer_end_value (sequencer -> timer);
//          timer_end_reached, timer_value (timer -> sequencer).
// Modports: master = sequencer side, slave = timer side.
interface round_controller_if #(
  parameter int TW = 13
);
  logic          timer_reset;
  logic          timer_enable;
  logic [TW-1:0] timer_end_value;
  logic          timer_end_reached;
  logic [TW-1:0] timer_value;

  modport master (
    output timer_reset,
    output timer_enable,
    output timer_end_value,
    input  timer_end_reached,
    input  timer_value
  );

  modport slave (
    input  timer_reset,
    input  timer_enable,
    input  timer_end_value,
    output timer_end_reached,
    output timer_value
  );
endinterface

// File: rtl/gap_delay.sv
// rtl/gap_delay.sv - load/count/done down-counter spanning CLKS clock cycles
// Ports: clk, reset (sync, active-high), load (start a new delay),
//        done (high in the last of the CLKS cycles after load).
module gap_delay #(
  parameter int CLKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);
  localparam int W = (CLKS > 1) ? $clog2(CLKS) : 1;

  logic [W-1:0] cnt;
  logic         busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (load) begin
      cnt  <= W'(CLKS - 1);
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

  // Combinational so the consumer can leave its wait state on the same edge.
  assign done = busy && (cnt == '0);
endmodule

// File: rtl/round_controller.sv
// rtl/round_controller.sv - game-round sequencer driving the millisecond timer
// Ports: clk, reset (sync, active-high), start, hit, hit_correct,
//        tmr (timer bus, master side), difficulty, new_target, score, lives,
//        round_idx, best_ms, game_over. All outputs are registered except the
//        constant timer_end_value.
module round_controller
  import game_pkg::*;
#(
  parameter int  MAX_MS       = 5000,
  parameter int  ROUND_MS     = 2000,
  parameter int  NUM_ROUNDS   = 10,
  parameter int  LIVES        = 3,
  parameter int  LEVEL_ROUNDS = 3,
  parameter int  GAP_CLKS     = 25000000,
  parameter int  SCORE_W      = 8,
  localparam int TW           = $clog2(MAX_MS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               hit,
  input  logic               hit_correct,
  round_controller_if.master tmr,
  output logic [3:0]         difficulty,
  output logic               new_target,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic [3:0]         round_idx,
  output logic [TW-1:0]      best_ms,
  output logic               game_over
);
  round_state_t state;
  logic [3:0]   hit_cnt;
  logic         gap_load;
  logic         gap_done;
  logic         to_over;

  assign tmr.timer_end_value = TW'(ROUND_MS);

  // Evaluated in SCORE, where lives already reflects this round's outcome
  // and round_idx still holds the pre-increment count.
  assign to_over  = (lives == 2'd0) || (round_idx + 4'd1 == 4'(NUM_ROUNDS));
  assign gap_load = (state == ST_SCORE) && !to_over;

  gap_delay #(.CLKS(GAP_CLKS)) u_gap (
    .clk  (clk),
    .reset(reset),
    .load (gap_load),
    .done (gap_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      score            <= '0;
      lives            <= 2'(LIVES);
      round_idx        <= '0;
      difficulty       <= DIFF_EASY;
      best_ms          <= '1;
      hit_cnt          <= '0;
      new_target       <= 1'b0;
      tmr.timer_enable <= 1'b0;
      tmr.timer_reset  <= 1'b1;
      game_over        <= 1'b0;
    end else begin
      new_target <= 1'b0;
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            score      <= '0;
            round_idx  <= '0;
            difficulty <= DIFF_EASY;
            best_ms    <= '1;
            hit_cnt    <= '0;
            lives      <= 2'(LIVES);
            game_over  <= 1'b0;
            // Registered, so the pulse lands in the single ARM cycle.
            new_target <= 1'b1;
            state      <= ST_ARM;
          end
        end
        ST_ARM: begin
          tmr.timer_reset  <= 1'b0;
          tmr.timer_enable <= 1'b1;
          state            <= ST_RUN;
        end
        ST_RUN: begin
          // A hit outranks a simultaneous timeout.
          if (hit && hit_correct) begin
            score <= SCORE_W'(sat_add(32'(score), 32'(difficulty) + 32'd1,
                                      32'({SCORE_W{1'b1}})));
            if (tmr.timer_value < best_ms) best_ms <= tmr.timer_value;
            if (hit_cnt + 4'd1 == 4'(LEVEL_ROUNDS)) begin
              hit_cnt <= '0;
              if (difficulty < DIFF_HARD) difficulty <= difficulty + 4'd1;
            end else begin
              hit_cnt <= hit_cnt + 4'd1;
            end
          end else if (hit || tmr.timer_end_reached) begin
            if (lives != 2'd0) lives <= lives - 2'd1;
          end
          if (hit || tmr.timer_end_reached) begin
            tmr.timer_reset  <= 1'b1;
            tmr.timer_enable <= 1'b0;
            state            <= ST_SCORE;
          end
        end
        ST_SCORE: begin
          round_idx <= round_idx + 4'd1;
          if (to_over) begin
            game_over <= 1'b1;
            state     <= ST_OVER;
          end else begin
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            new_target <= 1'b1;
            state      <= ST_ARM;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
